// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding,
// default operand widths and the step-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DIVIDEND_W = 5;
    localparam int DEF_DIVISOR_W  = 4;

    // Width of the down-counter that walks the dividend bits (DIVIDEND_W-1 .. 0).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor when it fits.
module div_step #(
    parameter int DIVIDEND_W = 5,
    parameter int DIVISOR_W  = 4
) (
    input  logic [DIVIDEND_W-1:0] r,
    input  logic                  bit_in,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] r_next,
    output logic                  q_bit
);

    logic [DIVIDEND_W:0] shifted_s;
    logic [DIVIDEND_W:0] dv_ext_s;

    // Compare at full DIVIDEND_W+1 width; the difference always fits back into DIVIDEND_W bits.
    always_comb begin
        shifted_s = {r, bit_in};
        dv_ext_s  = (DIVIDEND_W+1)'(divisor);
        if (shifted_s >= dv_ext_s) begin
            q_bit  = 1'b1;
            r_next = shifted_s[DIVIDEND_W-1:0] - dv_ext_s[DIVIDEND_W-1:0];
        end else begin
            q_bit  = 1'b0;
            r_next = shifted_s[DIVIDEND_W-1:0];
        end
    end

endmodule

// File: rtl/div_restoring.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on
// both sides. Optional macro DIV_ZERO_ERR_EN adds the div_zero flag and a
// fast path that skips the iteration for a zero divisor.
module div_restoring
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVIDEND_W-1:0] remainder
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic                  div_zero
`endif
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [DIVIDEND_W-1:0]   dvd_r;       // dividend shifting out, quotient shifting in
    logic [DIVISOR_W-1:0]    dvs_r;
    logic [DIVIDEND_W-1:0]   rem_work_r;  // partial remainder during RUN
    logic [DIVIDEND_W-1:0]   quotient_r;
    logic [DIVIDEND_W-1:0]   remainder_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [DIVIDEND_W-1:0]   r_next_s;
    logic                    q_bit_s;
`ifdef DIV_ZERO_ERR_EN
    logic                    div_zero_r;
`endif

    div_step #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_step (
        .r       (rem_work_r),
        .bit_in  (dvd_r[DIVIDEND_W-1]),
        .divisor (dvs_r),
        .r_next  (r_next_s),
        .q_bit   (q_bit_s)
    );

    // Next-state logic for the IDLE/RUN/DONE handshake FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
`ifdef DIV_ZERO_ERR_EN
                    if (divisor == {DIVISOR_W{1'b0}}) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
`else
                    state_nxt_s = RUN;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            dvd_r       <= {DIVIDEND_W{1'b0}};
            dvs_r       <= {DIVISOR_W{1'b0}};
            rem_work_r  <= {DIVIDEND_W{1'b0}};
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVIDEND_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef DIV_ZERO_ERR_EN
            div_zero_r  <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        dvd_r      <= dividend;
                        dvs_r      <= divisor;
                        rem_work_r <= {DIVIDEND_W{1'b0}};
                        cnt_r      <= CNT_W'(DIVIDEND_W - 1);
`ifdef DIV_ZERO_ERR_EN
                        if (divisor == {DIVISOR_W{1'b0}}) begin
                            quotient_r  <= {DIVIDEND_W{1'b1}};
                            remainder_r <= dividend;
                            div_zero_r  <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    rem_work_r <= r_next_s;
                    dvd_r      <= {dvd_r[DIVIDEND_W-2:0], q_bit_s};
                    cnt_r      <= cnt_r - CNT_W'(1);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        quotient_r  <= {dvd_r[DIVIDEND_W-2:0], q_bit_s};
                        remainder_r <= r_next_s;
                    end
                end
                DONE: begin
`ifdef DIV_ZERO_ERR_EN
                    if (out_ready) begin
                        div_zero_r <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
`ifdef DIV_ZERO_ERR_EN
    assign div_zero  = div_zero_r;
`endif

endmodule

// File: tb/tb_div_restoring.sv
// Directed self-checking bench for div_restoring (default widths 5/4).
// Follows DIV_ZERO_ERR_EN the same way the design does.
module tb_div_restoring;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] quotient;
    logic [4:0] remainder;
`ifdef DIV_ZERO_ERR_EN
    logic       div_zero;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    div_restoring dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_ERR_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running edge counter used to measure accept-to-accept spacing.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int zero_lat(input logic [3:0] b);
`ifdef DIV_ZERO_ERR_EN
        return (b == 4'd0) ? 1 : 6;
`else
        return 6;
`endif
    endfunction

    // Issue one operation from a negedge; returns at the negedge where out_valid is first seen.
    task automatic op(input string tag, input logic [4:0] a, input logic [3:0] b,
                      input int lat_exp, input logic [4:0] q_exp, input logic [4:0] r_exp,
                      output int acc_cyc);
        int guard;
        int lat;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        chk({tag, "_ready"}, int'(in_ready), 1);
        @(posedge clock);
        @(negedge clock);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, "_lat"}, lat, lat_exp);
        chk({tag, "_q"}, int'(quotient), int'(q_exp));
        chk({tag, "_r"}, int'(remainder), int'(r_exp));
`ifdef DIV_ZERO_ERR_EN
        chk({tag, "_dz"}, int'(div_zero), (b == 4'd0) ? 1 : 0);
`endif
    endtask

    initial begin
        int t0;
        int t1;
        int q_m;
        int r_m;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 5'd0;
        divisor   = 4'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
`ifdef DIV_ZERO_ERR_EN
        chk("rst_dz", int'(div_zero), 0);
`endif

        // 31 / 3
        op("d31_3", 5'd31, 4'd3, 6, 5'd10, 5'd1, t0);

        // 0 / 5 then 30 / 15 back to back
        op("d0_5", 5'd0, 4'd5, 6, 5'd0, 5'd0, t0);
        op("d30_15", 5'd30, 4'd15, 6, 5'd2, 5'd0, t1);
        chk("b2b_spacing", t1 - t0, 7);

        // 17 / 0
        op("d17_0", 5'd17, 4'd0, zero_lat(4'd0), 5'd31, 5'd17, t0);
        @(negedge clock);
        chk("d17_0_handshake", int'(out_valid), 0);
`ifdef DIV_ZERO_ERR_EN
        chk("d17_0_dz_clear", int'(div_zero), 0);
`endif

        // 29 / 4 with consumer stalling for 3 cycles
        out_ready = 1'b0;
        op("d29_4", 5'd29, 4'd4, 6, 5'd7, 5'd1, t0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            dividend = 5'd5;
            divisor  = 4'd1;
            @(posedge clock);
            @(negedge clock);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_q", int'(quotient), 7);
            chk("hold_r", int'(remainder), 1);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("hold_release_valid", int'(out_valid), 0);
        chk("hold_release_ready", int'(in_ready), 1);
        chk("hold_after_q", int'(quotient), 7);
        @(negedge clock);
        chk("no_queue_valid", int'(out_valid), 0);
        chk("no_queue_ready", int'(in_ready), 1);

        // Reset during RUN aborts the operation
        in_valid = 1'b1;
        dividend = 5'd21;
        divisor  = 4'd3;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        chk("abort_running", int'(in_ready), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_q", int'(quotient), 0);
        chk("abort_r", int'(remainder), 0);
        op("d9_2", 5'd9, 4'd2, 6, 5'd4, 5'd1, t0);

        // Exhaustive sweep of all operand pairs
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    q_m = 31;
                    r_m = a;
                end else begin
                    q_m = a / b;
                    r_m = a % b;
                end
                op("sweep", 5'(a), 4'(b), zero_lat(4'(b)), 5'(q_m), 5'(r_m), t0);
                if (b != 0) begin
                    chk("sweep_identity", int'(quotient) * b + int'(remainder), a);
                    chk("sweep_rem_lt", (int'(remainder) < b) ? 1 : 0, 1);
                end else begin
                    chk("sweep_dz_identity", int'(remainder), a);
                end
            end
        end

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
